// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback stage (package wb_pkg).
package wb_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  // Result source select
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_ALU3 = 2'd3
  } wb_sel_e;

  // Load width / signedness; undefined codes behave as LW
  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LBU = 3'd4,
    LT_LHU = 3'd5
  } load_type_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Fields of a load parked while its memory response is outstanding
  typedef struct packed {
    logic           we;
    logic [RAW-1:0] rd;
    logic [2:0]     lt;
    logic [1:0]     addr;
  } pend_t;

endpackage

// File: rtl/writeback_unit_if.sv
// MEM/WB handshake bundle: MEM stage + data memory inputs, register file write port outputs.
interface writeback_unit_if;
  import wb_pkg::*;

  logic            mem_valid;
  logic            mem_reg_we;
  logic [RAW-1:0]  mem_rd;
  logic [1:0]      mem_wb_sel;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_pc4;
  logic [2:0]      mem_load_type;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            wb_we;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_stall;

  modport master (
    output mem_valid, mem_reg_we, mem_rd, mem_wb_sel, mem_alu_result, mem_pc4,
           mem_load_type, dmem_rvalid, dmem_rdata,
    input  wb_we, wb_rd, wb_wdata, wb_stall
  );

  modport slave (
    input  mem_valid, mem_reg_we, mem_rd, mem_wb_sel, mem_alu_result, mem_pc4,
           mem_load_type, dmem_rvalid, dmem_rdata,
    output wb_we, wb_rd, wb_wdata, wb_stall
  );

endinterface

// File: rtl/writeback_unit_load_extend.sv
// Load data alignment and sign/zero extension (combinational).
module load_extend
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick byte/halfword lane, then extend by load type
  always_comb begin
    byte_sel = 8'h00;
    half_sel = addr[1] ? word[31:16] : word[15:0];
    ext      = word;
    case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    case (load_type)
      LT_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      LT_LH:   ext = {{16{half_sel[15]}}, half_sel};
      LT_LBU:  ext = {24'h0, byte_sel};
      LT_LHU:  ext = {16'h0, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: MEM/WB register, result select, load extension, x0 suppression,
// stall while a load response is outstanding.
// Optional retired-instruction counter enabled by macro WB_RETIRE_CNT_EN.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN = wb_pkg::XLEN,
  parameter int RAW  = wb_pkg::RAW
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_unit_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  wb_state_e       state_q, state_d;
  pend_t           pend_q, pend_d;
  logic            we_q, we_d;
  logic [RAW-1:0]  rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      ext_addr;
  logic [2:0]      ext_lt;
  logic [XLEN-1:0] ext_data;
  logic            waiting;

  assign waiting      = (state_q == ST_WAIT_LOAD);
  assign bus.wb_stall = waiting;
  assign bus.wb_we    = we_q;
  assign bus.wb_rd    = rd_q;
  assign bus.wb_wdata = wdata_q;

  // Single extender shared by the live load and the parked one
  always_comb begin
    ext_addr = waiting ? pend_q.addr : bus.mem_alu_result[1:0];
    ext_lt   = waiting ? pend_q.lt   : bus.mem_load_type;
  end

  load_extend u_ext (
    .word      (bus.dmem_rdata),
    .addr      (ext_addr),
    .load_type (ext_lt),
    .ext       (ext_data)
  );

  // Next state, pending load and write-port values
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    we_d    = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          if (bus.mem_wb_sel != WB_LOAD) begin
            we_d    = bus.mem_reg_we && (bus.mem_rd != '0);
            rd_d    = bus.mem_rd;
            wdata_d = (bus.mem_wb_sel == WB_PC4) ? bus.mem_pc4 : bus.mem_alu_result;
          end else if (bus.dmem_rvalid) begin
            we_d    = bus.mem_reg_we && (bus.mem_rd != '0);
            rd_d    = bus.mem_rd;
            wdata_d = ext_data;
          end else begin
            pend_d.we   = bus.mem_reg_we;
            pend_d.rd   = bus.mem_rd;
            pend_d.lt   = bus.mem_load_type;
            pend_d.addr = bus.mem_alu_result[1:0];
            state_d     = ST_WAIT_LOAD;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (bus.dmem_rvalid) begin
          we_d    = pend_q.we && (pend_q.rd != '0);
          rd_d    = pend_q.rd;
          wdata_d = ext_data;
          pend_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage registers; reset drops any parked load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic        retire;

  assign retired_cnt = retired_q;

  // An instruction completes on any edge that produces a (possibly suppressed) write
  always_comb begin
    retire = 1'b0;
    if (state_q == ST_IDLE)
      retire = bus.mem_valid && ((bus.mem_wb_sel != WB_LOAD) || bus.dmem_rvalid);
    else
      retire = bus.dmem_rvalid;
    retired_d = retired_q + {31'd0, retire};
  end

  // Retire counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized
// traffic against a behavioural model.
module tb_writeback_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  writeback_unit_if bus ();
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  writeback_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic        m_pend;
  logic        m_pwe;
  logic [4:0]  m_prd;
  logic [2:0]  m_plt;
  logic [1:0]  m_paddr;
  logic        e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_wdata;

  // Expected load value from plain shift/mask arithmetic
  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = a[1] ? (w >> 16) : (w & 32'hFFFF);
    case (t)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic rwe, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] lt,
                       input logic rv, input logic [31:0] rdata);
    bus.mem_valid      = mv;
    bus.mem_reg_we     = rwe;
    bus.mem_rd         = rd;
    bus.mem_wb_sel     = sel;
    bus.mem_alu_result = alu;
    bus.mem_pc4        = pc4;
    bus.mem_load_type  = lt;
    bus.dmem_rvalid    = rv;
    bus.dmem_rdata     = rdata;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", bus.wb_we); end
    checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.wb_rd); end
    checks++; if (bus.wb_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.wb_wdata); end
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.wb_stall); end
`ifdef WB_RETIRE_CNT_EN
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", retired_cnt); end
`endif
  endtask

  task automatic test_alu_write();
    drive(1, 1, 5, 2'd0, 32'h1234, 32'h0, 0, 0, 0);
    step();
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL alu_we got=%0b exp=1", bus.wb_we); end
    checks++; if (bus.wb_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", bus.wb_rd); end
    checks++; if (bus.wb_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata got=%h exp=00001234", bus.wb_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    step();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL idle_we got=%0b exp=0", bus.wb_we); end
    checks++; if (bus.wb_wdata !== 32'h1234) begin errors++; $display("FAIL idle_hold got=%h exp=00001234", bus.wb_wdata); end
  endtask

  task automatic test_x0();
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] c0;
    c0 = retired_cnt;
`endif
    drive(1, 1, 0, 2'd2, 32'h55, 32'h100, 0, 0, 0);
    step();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL x0_we got=%0b exp=0", bus.wb_we); end
    checks++; if (bus.wb_wdata !== 32'h100) begin errors++; $display("FAIL x0_wdata got=%h exp=00000100", bus.wb_wdata); end
`ifdef WB_RETIRE_CNT_EN
    checks++; if (retired_cnt !== c0 + 32'd1) begin errors++; $display("FAIL x0_cnt got=%h exp=%h", retired_cnt, c0 + 32'd1); end
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_same_cycle();
    drive(1, 1, 7, 2'd1, 32'h1003, 0, 3'd0, 1, 32'h80FF_7F01);
    step();
    checks++; if (bus.wb_we !== 1'b1 || bus.wb_wdata !== 32'hFFFF_FF80) begin errors++;
      $display("FAIL lb_same got we=%0b data=%h exp we=1 data=ffffff80", bus.wb_we, bus.wb_wdata); end
    drive(1, 1, 8, 2'd1, 32'h1003, 0, 3'd4, 1, 32'h80FF_7F01);
    step();
    checks++; if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd8 || bus.wb_wdata !== 32'h0000_0080) begin errors++;
      $display("FAIL lbu_same got we=%0b rd=%0d data=%h exp we=1 rd=8 data=00000080", bus.wb_we, bus.wb_rd, bus.wb_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_delayed_lh();
    drive(1, 1, 9, 2'd1, 32'h2002, 0, 3'd1, 0, 0);
    step();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL lh_issue_we got=%0b exp=0", bus.wb_we); end
    // MEM stage keeps offering an ALU op that must not be taken
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 12, 2'd0, 32'hABCD, 0, 0, (i == 2), 32'h8001_0000);
      checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL lh_stall[%0d] got=%0b exp=1", i, bus.wb_stall); end
      step();
      if (i < 2) begin
        checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL lh_wait_we[%0d] got=%0b exp=0", i, bus.wb_we); end
      end
    end
    checks++; if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd9 || bus.wb_wdata !== 32'hFFFF_8001) begin errors++;
      $display("FAIL lh_done got we=%0b rd=%0d data=%h exp we=1 rd=9 data=ffff8001", bus.wb_we, bus.wb_rd, bus.wb_wdata); end
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL lh_unstall got=%0b exp=0", bus.wb_stall); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd9) begin errors++;
      $display("FAIL lh_no_accept got we=%0b rd=%0d exp we=0 rd=9", bus.wb_we, bus.wb_rd); end
  endtask

  task automatic test_reset_mid_load();
    drive(1, 1, 4, 2'd1, 32'h0, 0, 3'd2, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.wb_stall !== 1'b0 || bus.wb_we !== 1'b0 || bus.wb_wdata !== 32'd0) begin errors++;
      $display("FAIL rst_mid_async got stall=%0b we=%0b data=%h exp 0/0/0", bus.wb_stall, bus.wb_we, bus.wb_wdata); end
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222);
    #1;
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%0b exp=0", bus.wb_stall); end
    step();
    checks++; if (bus.wb_we !== 1'b0 || bus.wb_wdata !== 32'd0) begin errors++;
      $display("FAIL rst_mid_nowrite got we=%0b data=%h exp we=0 data=0", bus.wb_we, bus.wb_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'(i + 1), (i % 2 == 0) ? 2'd3 : 2'd2, 32'hA000 + i, 32'hB000 + i, 0, 0, 0);
      step();
      checks++;
      if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'(i + 1) ||
          bus.wb_wdata !== ((i % 2 == 0) ? 32'hA000 + i : 32'hB000 + i)) begin
        errors++;
        $display("FAIL b2b[%0d] got we=%0b rd=%0d data=%h", i, bus.wb_we, bus.wb_rd, bus.wb_wdata);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic        mv, rwe, rv;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [31:0] alu, pc4, rdata;
    int          bad;
    do_reset();
    m_pend = 0; m_pwe = 0; m_prd = 0; m_plt = 0; m_paddr = 0;
    e_we = 0; e_rd = 0; e_wdata = 0;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      mv    = ($urandom_range(0, 3) != 0);
      rwe   = ($urandom_range(0, 4) != 0);
      rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      sel   = 2'($urandom);
      lt    = 3'($urandom);
      alu   = $urandom;
      pc4   = $urandom;
      rv    = ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      drive(mv, rwe, rd, sel, alu, pc4, lt, rv, rdata);
      #1;
      checks++;
      if (bus.wb_stall !== m_pend) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_stall[%0d] got=%0b exp=%0b", n, bus.wb_stall, m_pend);
      end
      e_we = 0;
      if (m_pend) begin
        if (rv) begin
          e_we = m_pwe && (m_prd != 0); e_rd = m_prd; e_wdata = m_ext(rdata, m_paddr, m_plt);
          m_pend = 0;
        end
      end else if (mv) begin
        if (sel != 2'd1) begin
          e_we = rwe && (rd != 0); e_rd = rd; e_wdata = (sel == 2'd2) ? pc4 : alu;
        end else if (rv) begin
          e_we = rwe && (rd != 0); e_rd = rd; e_wdata = m_ext(rdata, alu[1:0], lt);
        end else begin
          m_pend = 1; m_pwe = rwe; m_prd = rd; m_plt = lt; m_paddr = alu[1:0];
        end
      end
      step();
      checks++;
      if (bus.wb_we !== e_we || bus.wb_rd !== e_rd || bus.wb_wdata !== e_wdata) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_wb[%0d] got we=%0b rd=%0d data=%h exp we=%0b rd=%0d data=%h",
                               n, bus.wb_we, bus.wb_rd, bus.wb_wdata, e_we, e_rd, e_wdata);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_counter_wrap();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    drive(1, 1, 3, 2'd0, 32'h77, 0, 0, 0, 0);
    step();
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL cnt_wrap got=%h exp=0", retired_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_alu_write();
    test_x0();
    test_load_same_cycle();
    test_delayed_lh();
    test_reset_mid_load();
    test_back_to_back();
`ifdef WB_RETIRE_CNT_EN
    test_counter_wrap();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the five-stage pipeline: holds the MEM/WB pipeline register and drives the register file's write port (`we`/`rd`/`Wdata`). It selects the result source, aligns and sign- or zero-extends load data, and suppresses writes to x0. It also stalls upstream stages while a data-memory load response is outstanding.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `RAW`, 5: register address width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  MEM stage presents an instruction this cycle.
- `mem_reg_we`  in  1  instruction writes a destination register.
- `mem_rd`  in  RAW  destination register index.
- `mem_wb_sel`  in  2  result source: 0 = ALU, 1 = LOAD, 2 = PC+4, 3 = ALU.
- `mem_alu_result`  in  XLEN  ALU result, or effective address for loads.
- `mem_pc4`  in  XLEN  PC+4 for JAL/JALR.
- `mem_load_type`  in  3  0 = LB, 1 = LH, 2 = LW, 4 = LBU, 5 = LHU; other codes decode as LW.
- `dmem_rvalid`  in  1  data-memory read data valid.
- `dmem_rdata`  in  XLEN  raw aligned memory word.
- `wb_we`  out  1  register file write enable (registered).
- `wb_rd`  out  RAW  register file write index (registered).
- `wb_wdata`  out  XLEN  register file write data (registered).
- `wb_stall`  out  1  upstream must hold its instruction; `mem_valid` is ignored while high.
- `retired_cnt`  out  32  retired-instruction count; present only with `WB_RETIRE_CNT_EN`.

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE, `mem_valid` = 1, `mem_wb_sel` != LOAD:
  - Registers `wb_rd` = `mem_rd` and `wb_wdata` = selected result.
  - `wb_we` = `mem_reg_we` && (`mem_rd` != 0).
  - Stays in IDLE.
- IDLE, `mem_valid` = 1, `mem_wb_sel` = LOAD, `dmem_rvalid` = 1 in the same cycle:
  - Writes the extended load data directly; stays in IDLE.
- IDLE, `mem_valid` = 1, `mem_wb_sel` = LOAD, `dmem_rvalid` = 0:
  - Latches rd, reg_we, load_type and address bits [1:0] into a pending register.
  - `wb_we` = 0 on the next edge; moves to WAIT_LOAD.
- IDLE, `mem_valid` = 0: `wb_we` = 0 on the next edge. `wb_rd`/`wb_wdata` hold their values.
- WAIT_LOAD, `dmem_rvalid` = 0: `wb_we` = 0; stays in WAIT_LOAD.
- WAIT_LOAD, `dmem_rvalid` = 1: writes the extended pending load on the next edge; returns to IDLE.
- Load extension:
  - Byte selected by addr[1:0]; halfword selected by addr[1]; addr[0] is ignored for halfwords.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned accesses are not flagged.
- `dmem_rvalid` in IDLE without a LOAD `mem_valid` is ignored.
- `wb_stall` = (state == WAIT_LOAD), combinational, including the cycle in which `dmem_rvalid` arrives. Upstream therefore never presents a new instruction on the edge that completes a pending load.
- rd = 0: the instruction still completes and counts as retired, but `wb_we` stays 0.

## Timing
- Reset values: `wb_we` = 0, `wb_rd` = 0, `wb_wdata` = 0, state = IDLE, pending cleared, `retired_cnt` = 0.
- Reset asserted mid-load discards the pending load and performs no write.
- Non-load instructions: accepted at edge N, write visible in cycle N+1.
- Loads: `dmem_rvalid` sampled at edge K, write visible in cycle K+1. `wb_stall` is high from cycle N+1 through cycle K.
- Back-to-back non-load instructions sustain one write per cycle.
- The register file bypasses same-cycle writes, so no additional forwarding is required here.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - Adds `retired_cnt`, incremented by 1 on each edge that completes an instruction (writing or not).
  - Wraps from 0xFFFF_FFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `wb_pkg`:
  - `wb_sel_e`, `load_type_e`, `wb_state_e` enums.
  - Constants `XLEN` and `RAW`.
- One combinational sub-module, `load_extend`: inputs raw word, addr[1:0] and load_type; output the extended word. It is instantiated once, muxed between live and pending fields.

## Test plan
- ALU write: `mem_valid` = 1, sel = ALU, rd = 5, result = 0x1234 → cycle N+1: `wb_we` = 1, `wb_rd` = 5, `wb_wdata` = 0x0000_1234.
- x0 suppression: rd = 0, sel = PC+4, pc4 = 0x100 → `wb_we` = 0; `retired_cnt` increments by 1 (with `WB_RETIRE_CNT_EN`).
- Same-cycle LB: `dmem_rdata` = 0x80FF_7F01, addr[1:0] = 3, `dmem_rvalid` = 1 → `wb_wdata` = 0xFFFF_FF80; with LBU → 0x0000_0080.
- Delayed LH: addr[1:0] = 2; `rvalid` arrives 3 cycles later with 0x8001_0000 → `wb_stall` high for 3 cycles; then `wb_wdata` = 0xFFFF_8001, `wb_we` = 1; the `mem_valid` presented while stalled is not accepted.
- Reset mid-load: deassert `rst_n` in WAIT_LOAD, release, then pulse `dmem_rvalid` → no write, `wb_stall` = 0, state = IDLE.
- Counter wrap: preload `retired_cnt` to 0xFFFF_FFFF and retire one instruction → 0.
